stopwatch_lap: RTL and testbench

- Parametrised successor of the single-channel BCD stopwatch. Counts tenths, seconds units, seconds tens and a configurable number of minute digits.
- Control is edge-triggered: play toggles run and pause, stop clears, and lap freezes the display while counting continues.
- Sits between the push-button debouncers and the 7-segment display driver. Has an integrated tick prescaler, so no external temporizador is needed.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/bcd_digit.sv | 38 +++
 rtl/stopwatch_lap.sv | 164 ++++++++++++++++
 tb/tb_stopwatch_lap.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: FSM state encoding and BCD digit type.
package stopwatch_pkg;

   localparam int unsigned BCD_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_e;

   typedef logic [BCD_W-1:0] bcd_t;

   localparam bcd_t BCD_MAX      = 4'd9;
   localparam bcd_t SEC_TENS_MAX = 4'd5;

   // Prescaler and count advance only while the clock is live.
   function automatic logic is_counting(input state_e s);
      return (s == RUN) || (s == LAP);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit rolling over at MAX; carry is combinational so a
// whole chain of digits can ripple within a single clock edge.
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter bcd_t MAX = BCD_MAX
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic clr_i,
   output bcd_t value_o,
   output logic carry_c_o
);

   bcd_t value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (clr_i) begin
         value_d = '0;
      end else if (inc_i) begin
         value_d = (value_q == MAX) ? bcd_t'(0) : value_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value_o   = value_q;
   assign carry_c_o = inc_i & (value_q == MAX);

endmodule

// File: rtl/stopwatch_lap.sv
// BCD stopwatch with run/pause, clear and lap-freeze display plus integrated tick prescaler.
// Optional macro STOPWATCH_LAP_SPLIT_EN adds a saturating lap counter output (lap_cnt).
module stopwatch_lap
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 5000000,
   parameter int unsigned MIN_DIGITS = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    play,
   input  logic                    stop,
   input  logic                    lap,
   output bcd_t                    decimo,
   output bcd_t                    uni_segundo,
   output bcd_t                    dec_segundo,
   output logic [4*MIN_DIGITS-1:0] minuto,
   output logic                    running,
   output logic                    lap_frozen,
   output logic                    wrap
`ifdef STOPWATCH_LAP_SPLIT_EN
   ,
   output logic [3:0]              lap_cnt
`endif
);

   localparam int unsigned NDIG  = 3 + MIN_DIGITS;
   localparam int unsigned CW    = BCD_W * NDIG;
   localparam int unsigned PRE_W = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic             play_q, stop_q, lap_q;
   logic             play_e, stop_e, lap_e, lap_ok;
   state_e           state_q, state_d;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic             counting, tick;
   logic [NDIG-1:0]  inc, carry;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    disp_q, disp_d;
   logic             running_q, lap_frozen_q, wrap_q;

   assign play_e = play & ~play_q;
   assign stop_e = stop & ~stop_q;
   assign lap_e  = lap & ~lap_q;

`ifdef STOPWATCH_LAP_SPLIT_EN
   // A lap edge colliding with play never counts as an accepted lap.
   assign lap_ok = lap_e & ~play_e;
`else
   assign lap_ok = lap_e;
`endif

   assign counting = is_counting(state_q);
   assign tick     = counting & (presc_q == PRE_LAST);

   // Next state: stop beats play beats lap.
   always_comb begin
      state_d = state_q;
      if (stop_e) begin
         state_d = IDLE;
      end else if (play_e) begin
         state_d = counting ? PAUSE : RUN;
      end else if (lap_ok) begin
         if (state_q == RUN) begin
            state_d = LAP;
         end else if (state_q == LAP) begin
            state_d = RUN;
         end
      end
   end

   always_comb begin
      presc_d = presc_q;
      if (stop_e) begin
         presc_d = '0;
      end else if (counting) begin
         presc_d = tick ? '0 : presc_q + PRE_W'(1);
      end
   end

   // Digit chain: tenths, seconds units, seconds tens, then minutes.
   assign inc = {carry[NDIG-2:0], tick & ~stop_e};

   for (genvar i = 0; i < NDIG; i++) begin : g_dig
      localparam bcd_t DMAX = (i == 2) ? SEC_TENS_MAX : BCD_MAX;
      bcd_digit #(.MAX(DMAX)) u_digit (
         .clk       (clk),
         .rst_n     (rst_n),
         .inc_i     (inc[i]),
         .clr_i     (stop_e),
         .value_o   (cnt[BCD_W*i +: BCD_W]),
         .carry_c_o (carry[i])
      );
   end

   // Display follows the count except while staying in LAP; entering LAP latches the current count.
   always_comb begin
      disp_d = cnt;
      if (stop_e) begin
         disp_d = '0;
      end else if ((state_q == LAP) && (state_d == LAP)) begin
         disp_d = disp_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         play_q       <= 1'b0;
         stop_q       <= 1'b0;
         lap_q        <= 1'b0;
         state_q      <= IDLE;
         presc_q      <= '0;
         disp_q       <= '0;
         running_q    <= 1'b0;
         lap_frozen_q <= 1'b0;
         wrap_q       <= 1'b0;
      end else begin
         play_q       <= play;
         stop_q       <= stop;
         lap_q        <= lap;
         state_q      <= state_d;
         presc_q      <= presc_d;
         disp_q       <= disp_d;
         running_q    <= is_counting(state_d);
         lap_frozen_q <= (state_d == LAP);
         wrap_q       <= carry[NDIG-1];
      end
   end

`ifdef STOPWATCH_LAP_SPLIT_EN
   logic [3:0] lap_cnt_q, lap_cnt_d;
   logic       lap_acc;

   assign lap_acc = lap_ok & ~stop_e & counting;

   always_comb begin
      lap_cnt_d = lap_cnt_q;
      if (stop_e) begin
         lap_cnt_d = '0;
      end else if (lap_acc && (lap_cnt_q != 4'hF)) begin
         lap_cnt_d = lap_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_cnt_q <= '0;
      end else begin
         lap_cnt_q <= lap_cnt_d;
      end
   end

   assign lap_cnt = lap_cnt_q;
`endif

   assign decimo      = disp_q[3:0];
   assign uni_segundo = disp_q[7:4];
   assign dec_segundo = disp_q[11:8];
   assign minuto      = disp_q[CW-1:12];
   assign running     = running_q;
   assign lap_frozen  = lap_frozen_q;
   assign wrap        = wrap_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: directed timing checks plus random button activity
// compared every cycle against a tenths-of-a-second reference model.
module tb_stopwatch_lap;

   localparam int unsigned TICK_DIV   = 4;
   localparam int unsigned MIN_DIGITS = 1;
   localparam int MIN_SPAN = (MIN_DIGITS == 1) ? 10 : (MIN_DIGITS == 2) ? 100 : 1000;
   localparam int MAXT     = 600 * MIN_SPAN;

   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

   logic clk = 1'b0, rst_n = 1'b0;
   logic play = 1'b0, stop = 1'b0, lap = 1'b0;
   logic [3:0] decimo, uni_segundo, dec_segundo;
   logic [4*MIN_DIGITS-1:0] minuto;
   logic running, lap_frozen, wrap;
`ifdef STOPWATCH_LAP_SPLIT_EN
   logic [3:0] lap_cnt;
`endif

   int n_tests = 0, n_fail = 0;
   int cyc = 0;

   stopwatch_lap #(.TICK_DIV(TICK_DIV), .MIN_DIGITS(MIN_DIGITS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .play        (play),
      .stop        (stop),
      .lap         (lap),
      .decimo      (decimo),
      .uni_segundo (uni_segundo),
      .dec_segundo (dec_segundo),
      .minuto      (minuto),
      .running     (running),
      .lap_frozen  (lap_frozen),
      .wrap        (wrap)
`ifdef STOPWATCH_LAP_SPLIT_EN
      ,
      .lap_cnt     (lap_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] dut_disp, dut_view;
   assign dut_disp = 32'({decimo, uni_segundo, dec_segundo, minuto});
   assign dut_view = 32'({decimo, uni_segundo, dec_segundo, minuto, running, lap_frozen, wrap});

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [4*MIN_DIGITS-1:0] min_bcd(input int mins);
      logic [4*MIN_DIGITS-1:0] m;
      int r;
      r = mins;
      for (int i = 0; i < MIN_DIGITS; i++) begin
         m[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return m;
   endfunction

   // Display value written as m:ST.t (minutes, seconds tens, seconds units, tenths).
   function automatic logic [31:0] exp_disp(input int mn, input int st, input int su, input int te);
      return 32'({4'(te), 4'(su), 4'(st), min_bcd(mn)});
   endfunction

   function automatic logic [31:0] exp_view(input int t, input int st);
      return 32'({4'(t % 10), 4'((t / 10) % 10), 4'((t / 100) % 6), min_bcd(t / 600),
                  st == M_RUN || st == M_LAP, st == M_LAP, 1'b0});
   endfunction

   // Reference model: count kept as elapsed tenths, display as a snapshot of it.
   int m_st, m_presc, m_cnt, m_disp;
   bit m_wrap, m_pp, m_sp, m_lp;

   always @(posedge clk or negedge rst_n) begin : model
      int ns;
      bit pe, se, le, go, tk;
      if (!rst_n) begin
         m_st <= M_IDLE; m_presc <= 0; m_cnt <= 0; m_disp <= 0;
         m_wrap <= 1'b0; m_pp <= 1'b0; m_sp <= 1'b0; m_lp <= 1'b0;
      end else begin
         pe = play && !m_pp;
         se = stop && !m_sp;
         le = lap && !m_lp;
         go = (m_st == M_RUN) || (m_st == M_LAP);
         tk = go && (m_presc == TICK_DIV - 1);
         ns = m_st;
         if (se)                ns = M_IDLE;
         else if (pe)           ns = go ? M_PAUSE : M_RUN;
         else if (le && go)     ns = (m_st == M_RUN) ? M_LAP : M_RUN;
         m_st    <= ns;
         m_disp  <= se ? 0 : ((m_st == M_LAP && ns == M_LAP) ? m_disp : m_cnt);
         m_cnt   <= se ? 0 : (tk ? (m_cnt + 1) % MAXT : m_cnt);
         m_wrap  <= !se && tk && (m_cnt == MAXT - 1);
         m_presc <= se ? 0 : (go ? (tk ? 0 : m_presc + 1) : m_presc);
         m_pp <= play; m_sp <= stop; m_lp <= lap;
      end
   end

   always @(negedge clk) begin
      if (rst_n) check("model", dut_view, exp_view(m_disp, m_st) | 32'(m_wrap));
   end

   task automatic at_edge(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Raise one input so that posedge number c is its rising edge; returns at the following negedge.
   task automatic press(input int which, input int c);
      while (cyc < c - 1) @(negedge clk);
      case (which)
         0: play = 1'b1;
         1: stop = 1'b1;
         default: lap = 1'b1;
      endcase
      @(negedge clk);
      play = 1'b0; stop = 1'b0; lap = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int p, r;
      repeat (3) @(negedge clk);
      check("reset_view", dut_view, 32'd0);
      rst_n = 1'b1;

      // First tick lands TICK_DIV edges after play, display one edge later.
      p = cyc + 2;
      press(0, p);
      check("run_on", 32'(running), 32'd1);
      at_edge(p + 4);
      check("lat_pre", 32'(decimo), 32'd0);
      at_edge(p + 5);
      check("lat_first", 32'(decimo), 32'd1);
      at_edge(p + 2400);
      check("disp_0_59_9", dut_disp, exp_disp(0, 5, 9, 9));
      at_edge(p + 2401);
      check("disp_1_00_0", dut_disp, exp_disp(1, 0, 0, 0));

      press(1, cyc + 2);
      check("stop_clear", dut_view, 32'd0);

      // Pause at 0:03.2 with prescaler held at 2, resume after TICK_DIV-2 edges.
      p = cyc + 3;
      press(0, p);
      press(0, p + 130);
      at_edge(p + 180);
      check("pause_hold", dut_disp, exp_disp(0, 0, 3, 2));
      check("pause_run", 32'(running), 32'd0);
      r = p + 185;
      press(0, r);
      at_edge(r + TICK_DIV - 2);
      check("resume_pre", dut_disp, exp_disp(0, 0, 3, 2));
      at_edge(r + TICK_DIV - 1);
      check("resume_inc", dut_disp, exp_disp(0, 0, 3, 3));

      // Lap at 0:01.5, 20 ticks frozen, then release shows 0:03.5.
      press(1, cyc + 2);
      p = cyc + 3;
      press(0, p);
      press(2, p + 62);
      check("lap_on", 32'(lap_frozen), 32'd1);
      at_edge(p + 141);
      check("lap_hold", dut_disp, exp_disp(0, 0, 1, 5));
      press(2, p + 142);
      check("lap_release", dut_disp, exp_disp(0, 0, 3, 5));
      check("lap_off", 32'({running, lap_frozen}), 32'b10);

      // Full-range rollover.
      press(1, cyc + 2);
      p = cyc + 3;
      press(0, p);
      at_edge(p + 23999);
      check("max_disp", dut_disp, exp_disp(9, 5, 9, 9));
      check("wrap_pre", 32'(wrap), 32'd0);
      at_edge(p + 24000);
      check("wrap_hi", 32'(wrap), 32'd1);
      at_edge(p + 24001);
      check("wrap_lo", 32'(wrap), 32'd0);
      check("wrap_zero", dut_disp, exp_disp(0, 0, 0, 0));

      // Stop and play on the same edge: stop wins.
      at_edge(cyc + 5);
      play = 1'b1; stop = 1'b1;
      @(negedge clk);
      play = 1'b0; stop = 1'b0;
      check("stop_play", dut_view, 32'd0);

      // Asynchronous reset mid-count, sampled before any clock edge.
      press(0, cyc + 2);
      at_edge(cyc + 37);
      check("count_live", 32'(running), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("async_rst", dut_view, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      repeat (4000) begin
         @(negedge clk);
         if ($urandom_range(0, 99) < 6) play = ~play;
         if ($urandom_range(0, 99) < 2) stop = ~stop;
         if ($urandom_range(0, 99) < 5) lap  = ~lap;
      end
      play = 1'b0; stop = 1'b0; lap = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
